// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the unified memory bus arbiter: word width, constants, FSM states.
// MEM_BUS_TIMEOUT_EN is left undefined by default (no bus timeout).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef ZEROWORD
`define ZEROWORD {`XLEN{1'b0}}
`endif

package mem_bus_arb_pkg;

  localparam int XLEN = `XLEN;
  localparam logic [XLEN-1:0] ZERO_WORD = `ZEROWORD;
  localparam logic [3:0] BE_FULL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_LS_BUSY = 2'd2
  } arb_state_e;

  // Bits needed to hold the values 0..maxval.
  function automatic int cnt_width(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arb_sat_counter.sv
// Saturating up-counter with clear priority; hit is high while the count sits at LIMIT.
module bus_sat_counter #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIM)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_hit = (r_count == LIM);

endmodule

// File: rtl/mem_bus_arb.sv
// Unified memory bus arbiter: fetch vs. load/store, LSU priority with fetch anti-starvation.
// Define MEM_BUS_TIMEOUT_EN to abort transactions that see no bus_ack within TIMEOUT_CYCLES.
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  input  logic            i_if_flush,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,
  output logic            o_if_err,
  input  logic            i_ls_req,
  input  logic            i_ls_we,
  input  logic [XLEN-1:0] i_ls_addr,
  input  logic [XLEN-1:0] i_ls_wdata,
  input  logic [3:0]      i_ls_wstrb,
  output logic            o_ls_gnt,
  output logic            o_ls_rvalid,
  output logic [XLEN-1:0] o_ls_rdata,
  output logic            o_ls_err,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [XLEN-1:0] o_bus_wdata,
  output logic [3:0]      o_bus_be,
  input  logic            i_bus_ack,
  input  logic [XLEN-1:0] i_bus_rdata
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_kill;
  logic       w_kill_nxt;

  logic            r_bus_req;
  logic            r_bus_we;
  logic [XLEN-1:0] r_bus_addr;
  logic [XLEN-1:0] r_bus_wdata;
  logic [3:0]      r_bus_be;

  logic            r_if_rvalid;
  logic [XLEN-1:0] r_if_rdata;
  logic            r_if_err;
  logic            r_ls_rvalid;
  logic [XLEN-1:0] r_ls_rdata;
  logic            r_ls_err;

  logic w_gnt_if;
  logic w_gnt_ls;
  logic w_busy;
  logic w_done;
  logic w_abort;
  logic w_finish;
  logic w_starve_hit;
  logic w_if_deliver;

  // Forced fetch grant only when the LSU has won STARVE_LIMIT contested cycles in a row.
  always_comb begin
    w_gnt_if = 1'b0;
    w_gnt_ls = 1'b0;
    if ((r_state == ST_IDLE) && !i_rst) begin
      if (i_if_req && !i_if_flush && (w_starve_hit || !i_ls_req)) begin
        w_gnt_if = 1'b1;
      end else if (i_ls_req) begin
        w_gnt_ls = 1'b1;
      end
    end
  end

  bus_sat_counter #(
    .WIDTH (cnt_width(STARVE_LIMIT)),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_gnt_ls && i_if_req),
    .i_clr (w_gnt_if),
    .o_hit (w_starve_hit)
  );

  assign w_busy = (r_state != ST_IDLE);
  assign w_done = w_busy && i_bus_ack;

`ifdef MEM_BUS_TIMEOUT_EN
  logic w_to_hit;

  // Hits on the TIMEOUT_CYCLES-th busy cycle, so bus_req is held exactly that long.
  bus_sat_counter #(
    .WIDTH (cnt_width(TIMEOUT_CYCLES)),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_timeout_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_busy && !i_bus_ack),
    .i_clr (w_gnt_if || w_gnt_ls),
    .o_hit (w_to_hit)
  );

  assign w_abort = w_busy && !i_bus_ack && w_to_hit;
`else
  assign w_abort = 1'b0;
`endif

  assign w_finish     = w_done || w_abort;
  assign w_if_deliver = !r_kill && !i_if_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_if) begin
          w_state_nxt = ST_IF_BUSY;
        end else if (w_gnt_ls) begin
          w_state_nxt = ST_LS_BUSY;
        end
      end
      ST_IF_BUSY: begin
        if (w_finish) begin
          w_state_nxt = ST_IDLE;
          w_kill_nxt  = 1'b0;
        end else if (i_if_flush) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_LS_BUSY: begin
        if (w_finish) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_kill_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= ZERO_WORD;
      r_bus_wdata <= ZERO_WORD;
      r_bus_be    <= 4'b0000;
    end else if (w_gnt_if) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= i_if_addr;
      r_bus_wdata <= ZERO_WORD;
      r_bus_be    <= BE_FULL;
    end else if (w_gnt_ls) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= i_ls_we;
      r_bus_addr  <= i_ls_addr;
      r_bus_wdata <= i_ls_wdata;
      r_bus_be    <= i_ls_wstrb;
    end else if (w_finish) begin
      r_bus_req <= 1'b0;
    end
  end

  // rdata registers hold between pulses; a killed fetch leaves if_rdata untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= ZERO_WORD;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= ZERO_WORD;
      r_ls_err    <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      if (w_finish && (r_state == ST_IF_BUSY) && w_if_deliver) begin
        r_if_rvalid <= 1'b1;
        r_if_err    <= w_abort;
        r_if_rdata  <= w_abort ? ZERO_WORD : i_bus_rdata;
      end
      if (w_finish && (r_state == ST_LS_BUSY)) begin
        r_ls_rvalid <= 1'b1;
        r_ls_err    <= w_abort;
        r_ls_rdata  <= (w_abort || r_bus_we) ? ZERO_WORD : i_bus_rdata;
      end
    end
  end

  assign o_if_gnt    = w_gnt_if;
  assign o_ls_gnt    = w_gnt_ls;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_if_err    = r_if_err;
  assign o_ls_rvalid = r_ls_rvalid;
  assign o_ls_rdata  = r_ls_rdata;
  assign o_ls_err    = r_ls_err;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_be    = r_bus_be;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Testbench for mem_bus_arb: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbitration and response rules.
module tb_mem_bus_arb;

  localparam int STARVE = 4;
  localparam int TO     = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, ifFlush, ifGnt, ifRvalid, ifErr;
  logic [31:0] ifAddr, ifRdata;
  logic        lsReq, lsWe, lsGnt, lsRvalid, lsErr;
  logic [31:0] lsAddr, lsWdata, lsRdata;
  logic [3:0]  lsWstrb;
  logic        busReq, busWe, busAck;
  logic [31:0] busAddr, busWdata, busRdata;
  logic [3:0]  busBe;

  always #5 clk = ~clk;

  mem_bus_arb #(
    .STARVE_LIMIT   (STARVE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_if_req    (ifReq),
    .i_if_addr   (ifAddr),
    .i_if_flush  (ifFlush),
    .o_if_gnt    (ifGnt),
    .o_if_rvalid (ifRvalid),
    .o_if_rdata  (ifRdata),
    .o_if_err    (ifErr),
    .i_ls_req    (lsReq),
    .i_ls_we     (lsWe),
    .i_ls_addr   (lsAddr),
    .i_ls_wdata  (lsWdata),
    .i_ls_wstrb  (lsWstrb),
    .o_ls_gnt    (lsGnt),
    .o_ls_rvalid (lsRvalid),
    .o_ls_rdata  (lsRdata),
    .o_ls_err    (lsErr),
    .o_bus_req   (busReq),
    .o_bus_we    (busWe),
    .o_bus_addr  (busAddr),
    .o_bus_wdata (busWdata),
    .o_bus_be    (busBe),
    .i_bus_ack   (busAck),
    .i_bus_rdata (busRdata)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: owner 0 = none, 1 = fetch, 2 = LSU.
  int          mOwner;
  int          mStarve;
  bit          mKill;
  logic        mBusReq, mBusWe;
  logic [31:0] mBusAddr, mBusWdata;
  logic [3:0]  mBusBe;
  logic        mIfRvalid, mIfErr, mLsRvalid, mLsErr;
  logic [31:0] mIfRdata, mLsRdata;
  logic        expIfGnt, expLsGnt;
`ifdef MEM_BUS_TIMEOUT_EN
  int          mTo;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOwner = 0; mStarve = 0; mKill = 1'b0;
    mBusReq = 1'b0; mBusWe = 1'b0; mBusAddr = '0; mBusWdata = '0; mBusBe = '0;
    mIfRvalid = 1'b0; mIfErr = 1'b0; mIfRdata = '0;
    mLsRvalid = 1'b0; mLsErr = 1'b0; mLsRdata = '0;
`ifdef MEM_BUS_TIMEOUT_EN
    mTo = 0;
`endif
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit aRst, input bit aIfReq, input logic [31:0] aIfAddr,
                               input bit aFlush, input bit aLsReq, input bit aLsWe,
                               input logic [31:0] aLsAddr, input logic [31:0] aLsWdata,
                               input logic [3:0] aLsWstrb, input bit aAck,
                               input logic [31:0] aRdata);
    bit finish;
    bit abort;
    @(negedge clk);
    rst = aRst; ifReq = aIfReq; ifAddr = aIfAddr; ifFlush = aFlush;
    lsReq = aLsReq; lsWe = aLsWe; lsAddr = aLsAddr; lsWdata = aLsWdata; lsWstrb = aLsWstrb;
    busAck = aAck; busRdata = aRdata;
    #1;
    expIfGnt = 1'b0;
    expLsGnt = 1'b0;
    if (!aRst && mOwner == 0) begin
      if (aIfReq && !aFlush && (!aLsReq || mStarve == STARVE)) expIfGnt = 1'b1;
      else if (aLsReq) expLsGnt = 1'b1;
    end
    checkBit("if_gnt", ifGnt, expIfGnt);
    checkBit("ls_gnt", lsGnt, expLsGnt);
    checkBit("bus_req", busReq, mBusReq);
    checkBit("if_rvalid", ifRvalid, mIfRvalid);
    checkBit("if_err", ifErr, mIfErr);
    checkOutput("if_rdata", ifRdata, mIfRdata);
    checkBit("ls_rvalid", lsRvalid, mLsRvalid);
    checkBit("ls_err", lsErr, mLsErr);
    checkOutput("ls_rdata", lsRdata, mLsRdata);
    if (mBusReq) begin
      checkBit("bus_we", busWe, mBusWe);
      checkOutput("bus_addr", busAddr, mBusAddr);
      checkOutput("bus_be", {28'd0, busBe}, {28'd0, mBusBe});
      if (mBusWe) checkOutput("bus_wdata", busWdata, mBusWdata);
    end

    mIfRvalid = 1'b0; mIfErr = 1'b0; mLsRvalid = 1'b0; mLsErr = 1'b0;
    finish = 1'b0;
    abort  = 1'b0;
    if (aRst) begin
      modelReset();
    end else begin
      if (mOwner != 0) begin
        if (aAck) finish = 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
        else begin
          mTo++;
          if (mTo >= TO) begin finish = 1'b1; abort = 1'b1; end
        end
`endif
      end
      if (finish) begin
        if (mOwner == 1) begin
          if (!mKill && !aFlush) begin
            mIfRvalid = 1'b1; mIfErr = abort; mIfRdata = abort ? 32'h0 : aRdata;
          end
          mKill = 1'b0;
        end else begin
          mLsRvalid = 1'b1; mLsErr = abort;
          mLsRdata = (abort || mBusWe) ? 32'h0 : aRdata;
        end
        mOwner = 0;
        mBusReq = 1'b0;
      end else if (mOwner == 1 && aFlush) begin
        mKill = 1'b1;
      end
      if (expIfGnt) begin
        mOwner = 1; mBusReq = 1'b1; mBusWe = 1'b0; mBusAddr = aIfAddr; mBusBe = 4'hF;
        mStarve = 0;
`ifdef MEM_BUS_TIMEOUT_EN
        mTo = 0;
`endif
      end else if (expLsGnt) begin
        mOwner = 2; mBusReq = 1'b1; mBusWe = aLsWe; mBusAddr = aLsAddr;
        mBusWdata = aLsWdata; mBusBe = aLsWstrb;
        if (aIfReq && mStarve < STARVE) mStarve++;
`ifdef MEM_BUS_TIMEOUT_EN
        mTo = 0;
`endif
      end
    end
  endtask

  task automatic idleCycle(input bit aAck, input logic [31:0] aRdata);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, aAck, aRdata);
  endtask

  initial begin
    bit          ifPend, lsPend, lsW, fl, ack, doRst;
    logic [31:0] ifA, lsA, lsD;
    logic [3:0]  lsS;

    rst = 1'b1; ifReq = 1'b0; ifAddr = '0; ifFlush = 1'b0;
    lsReq = 1'b0; lsWe = 1'b0; lsAddr = '0; lsWdata = '0; lsWstrb = '0;
    busAck = 1'b0; busRdata = '0;
    repeat (2) @(posedge clk);
    modelReset();
    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 32'h1);
    checkBit("rst_no_gnt", lsGnt, 1'b0);

    $display("[TB] single load");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 32'h0);
    checkBit("load_gnt_c0", lsGnt, 1'b1);
    idleCycle(1'b0, 32'h0);
    checkBit("load_busreq_c1", busReq, 1'b1);
    idleCycle(1'b0, 32'h0);
    idleCycle(1'b1, 32'hDEADBEEF);
    checkBit("load_busreq_c3", busReq, 1'b1);
    idleCycle(1'b0, 32'h0);
    checkBit("load_rvalid_c4", lsRvalid, 1'b1);
    checkOutput("load_rdata_c4", lsRdata, 32'hDEADBEEF);
    checkBit("load_busreq_c4", busReq, 1'b0);

    $display("[TB] store");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h0000ABCD, 4'b0011, 1'b0, 32'h0);
    idleCycle(1'b0, 32'h0);
    checkOutput("store_be", {28'd0, busBe}, 32'h3);
    checkBit("store_we", busWe, 1'b1);
    checkOutput("store_wdata", busWdata, 32'h0000ABCD);
    idleCycle(1'b1, 32'h55555555);
    idleCycle(1'b0, 32'h0);
    checkBit("store_rvalid", lsRvalid, 1'b1);
    checkOutput("store_rdata", lsRdata, 32'h0);

    $display("[TB] contention");
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b1, 32'h1000 + c);
      checkBit("cont_if_gnt", ifGnt, (c == 8));
      checkBit("cont_ls_gnt", lsGnt, (c % 2 == 0) && (c != 8));
    end
    idleCycle(1'b0, 32'h0);

    $display("[TB] flush");
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    checkBit("flush_gnt", ifGnt, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    idleCycle(1'b1, 32'h00000013);
    applyStimulus(1'b0, 1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    checkBit("flush_suppressed", ifRvalid, 1'b0);
    checkBit("refetch_gnt", ifGnt, 1'b1);
    idleCycle(1'b1, 32'h00000093);
    idleCycle(1'b0, 32'h0);
    checkBit("refetch_rvalid", ifRvalid, 1'b1);
    checkOutput("refetch_rdata", ifRdata, 32'h00000093);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0, 32'h0);
    idleCycle(1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    idleCycle(1'b1, 32'h0000CAFE);
    checkBit("rstmid_busreq", busReq, 1'b0);
    idleCycle(1'b0, 32'h0);
    checkBit("rstmid_no_rvalid", lsRvalid, 1'b0);

`ifdef MEM_BUS_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    for (int c = 1; c <= TO; c++) idleCycle(1'b0, 32'h0);
    checkBit("to_busreq_last", busReq, 1'b1);
    idleCycle(1'b0, 32'h0);
    checkBit("to_busreq_drop", busReq, 1'b0);
    checkBit("to_rvalid", ifRvalid, 1'b1);
    checkBit("to_err", ifErr, 1'b1);
    checkOutput("to_rdata", ifRdata, 32'h0);
`endif

    $display("[TB] random traffic");
    ifPend = 1'b0; lsPend = 1'b0;
    ifA = '0; lsA = '0; lsD = '0; lsW = 1'b0; lsS = 4'hF;
    for (int c = 0; c < 400; c++) begin
      if (!ifPend && $urandom_range(0, 2) == 0) begin
        ifPend = 1'b1;
        ifA = $urandom() & 32'hFFFF_FFFC;
      end
      if (!lsPend && $urandom_range(0, 1) == 0) begin
        lsPend = 1'b1;
        lsA = $urandom();
        lsD = $urandom();
        lsW = 1'($urandom_range(0, 1));
        lsS = 4'($urandom_range(1, 15));
      end
      fl = ($urandom_range(0, 9) == 0);
      ack = mBusReq ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      doRst = ($urandom_range(0, 99) == 0);
      applyStimulus(doRst, ifPend, ifA, fl, lsPend, lsW, lsA, lsD, lsS, ack, $urandom());
      if (expIfGnt) ifPend = 1'b0;
      if (expLsGnt) lsPend = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
